// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcode encoding and fetch FSM states.
package cpu_pkg;

  localparam int DATA_WIDTH        = 11;
  localparam int INSTRUCTION_WIDTH = 15;
  localparam int OPCODE_WIDTH      = INSTRUCTION_WIDTH - DATA_WIDTH + 1;
  localparam int MAX_WAIT          = 8;

  typedef enum logic [OPCODE_WIDTH-1:0] {
    HLT = '0, STO, LD, LDI, ADD, ADDI, SUB, SUBI,
    BEQ, BNE, BGT, BGE, BLT, BLE, JMP
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FAULT
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Decoder-strobe, instruction-memory and IR/PC status signals of the fetch unit.
interface fetch_unit_if #(
  parameter int DW = cpu_pkg::DATA_WIDTH,
  parameter int IW = cpu_pkg::INSTRUCTION_WIDTH
);

  logic          fetch_req_in;
  logic          pc_wr_in;
  logic          branch_in;
  logic          pc_reset_in;
  logic          ir_reset_in;
  logic          imem_req_out;
  logic [DW-1:0] imem_addr_out;
  logic          imem_ack_in;
  logic [IW:0]   imem_data_in;
  logic [IW-DW:0] op_code_out;
  logic [DW-1:0] operand_out;
  logic [DW-1:0] pc_out;
  logic          ir_valid_out;
  logic          busy_out;
  logic          fault_out;

  modport slave (
    input  fetch_req_in, pc_wr_in, branch_in, pc_reset_in, ir_reset_in,
    input  imem_ack_in, imem_data_in,
    output imem_req_out, imem_addr_out, op_code_out, operand_out, pc_out,
    output ir_valid_out, busy_out, fault_out
  );

  modport master (
    output fetch_req_in, pc_wr_in, branch_in, pc_reset_in, ir_reset_in,
    output imem_ack_in, imem_data_in,
    input  imem_req_out, imem_addr_out, op_code_out, operand_out, pc_out,
    input  ir_valid_out, busy_out, fault_out
  );

endinterface

// File: rtl/program_counter.sv
// Program counter: synchronous clear, branch load or wrapping increment.
module program_counter import cpu_pkg::*; #(
  parameter int W = DATA_WIDTH
) (
  input  logic         clock_in,
  input  logic         reset_in,
  input  logic         clr_i,
  input  logic         wr_i,
  input  logic         branch_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_next_o
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  // Clear beats write; increment wraps naturally at W bits.
  always_comb begin
    pc_d = pc_q;
    if (clr_i) begin
      pc_d = '0;
    end else if (wr_i) begin
      pc_d = branch_i ? load_val_i : pc_q + W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o      = pc_q;
  assign pc_next_o = pc_d;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch responder: owns PC and IR, fetches words over req/ack.
//   state | meaning
//   IDLE  | waiting for a fetch request; PC updates accepted
//   FETCH | imem_req high, address held, waiting for ack
//   FAULT | ack timeout; left only through pc_reset_in or reset
module fetch_unit import cpu_pkg::*; (
  input logic        clock_in,
  input logic        reset_in,
  fetch_unit_if.slave bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  fetch_state_t               state_q;
  logic [WAIT_W-1:0]          wait_q;
  logic                       req_q;
  logic                       valid_q;
  logic                       fault_q;
  logic [DATA_WIDTH-1:0]      addr_q;
  logic [INSTRUCTION_WIDTH:0] ir_q;
  logic [DATA_WIDTH-1:0]      pc;
  logic [DATA_WIDTH-1:0]      pc_next;
  logic                       idle;

  assign idle = (state_q == IDLE);

  program_counter #(.W(DATA_WIDTH)) u_pc (
    .clock_in   (clock_in),
    .reset_in   (reset_in),
    .clr_i      (bus.pc_reset_in),
    .wr_i       (idle && bus.pc_wr_in),
    .branch_i   (bus.branch_in),
    .load_val_i (ir_q[DATA_WIDTH-1:0]),
    .pc_o       (pc),
    .pc_next_o  (pc_next)
  );

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      wait_q  <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
    end else begin
      if (bus.pc_reset_in) begin
        state_q <= IDLE;
        req_q   <= 1'b0;
        wait_q  <= '0;
        fault_q <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (bus.fetch_req_in) begin
              state_q <= FETCH;
              req_q   <= 1'b1;
              addr_q  <= pc_next;
              valid_q <= 1'b0;
              wait_q  <= '0;
            end
          end
          FETCH: begin
            if (bus.fetch_req_in || bus.pc_wr_in) begin
              fault_q <= 1'b1;
            end
            if (bus.imem_ack_in) begin
              state_q <= IDLE;
              req_q   <= 1'b0;
              wait_q  <= '0;
              ir_q    <= bus.imem_data_in;
              valid_q <= 1'b1;
            end else begin
              wait_q <= wait_q + WAIT_W'(1);
              if (wait_q == WAIT_LAST) begin
                state_q <= FAULT;
                req_q   <= 1'b0;
                fault_q <= 1'b1;
              end
            end
          end
          FAULT: begin
            state_q <= FAULT;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
      // IR clear overrides a coincident ack load; the fetch still completes.
      if (bus.ir_reset_in) begin
        ir_q    <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.imem_req_out  = req_q;
  assign bus.imem_addr_out = addr_q;
  assign bus.op_code_out   = ir_q[INSTRUCTION_WIDTH:DATA_WIDTH];
  assign bus.operand_out   = ir_q[DATA_WIDTH-1:0];
  assign bus.pc_out        = pc;
  assign bus.ir_valid_out  = valid_q;
  assign bus.busy_out      = !idle;
  assign bus.fault_out     = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed table, corner sequences, random vs model.
module tb_fetch_unit;

  typedef struct packed {
    logic [10:0] pc;
    logic        req;
    logic [10:0] addr;
    logic        vld;
    logic        busy;
    logic        flt;
    logic [4:0]  op;
    logic [10:0] opd;
  } outs_t;

  typedef struct {
    logic        fr, pw, br, prst, irst, ack;
    logic [15:0] data;
    outs_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_err = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clock_in (clk),
    .reset_in (rst_n),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  // Reference model state (plain integers)
  int m_pc, m_ir, m_addr, m_mode, m_wait, m_req, m_valid, m_fault;

  function automatic outs_t sample();
    outs_t o;
    o.pc   = bus.pc_out;
    o.req  = bus.imem_req_out;
    o.addr = bus.imem_addr_out;
    o.vld  = bus.ir_valid_out;
    o.busy = bus.busy_out;
    o.flt  = bus.fault_out;
    o.op   = bus.op_code_out;
    o.opd  = bus.operand_out;
    return o;
  endfunction

  function automatic string fmt(input outs_t o);
    return $sformatf("pc=%h req=%0b addr=%h vld=%0b busy=%0b flt=%0b op=%h opd=%h",
                     o.pc, o.req, o.addr, o.vld, o.busy, o.flt, o.op, o.opd);
  endfunction

  function automatic outs_t mk_out(input logic [10:0] pc, input logic req, input logic [10:0] addr,
                                   input logic vld, input logic busy, input logic flt,
                                   input logic [4:0] op, input logic [10:0] opd);
    outs_t o;
    o.pc = pc; o.req = req; o.addr = addr; o.vld = vld;
    o.busy = busy; o.flt = flt; o.op = op; o.opd = opd;
    return o;
  endfunction

  function automatic vec_t mk_vec(input logic fr, input logic pw, input logic br, input logic prst,
                                  input logic irst, input logic ack, input logic [15:0] d,
                                  input outs_t exp);
    vec_t v;
    v.fr = fr; v.pw = pw; v.br = br; v.prst = prst; v.irst = irst; v.ack = ack;
    v.data = d; v.exp = exp;
    return v;
  endfunction

  task automatic check_outs(input string name, input outs_t exp);
    outs_t act;
    act = sample();
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %s required %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fr, input logic pw, input logic br, input logic prst,
                       input logic irst, input logic ack, input logic [15:0] d);
    bus.fetch_req_in = fr;
    bus.pc_wr_in     = pw;
    bus.branch_in    = br;
    bus.pc_reset_in  = prst;
    bus.ir_reset_in  = irst;
    bus.imem_ack_in  = ack;
    bus.imem_data_in = d;
  endtask

  // Apply inputs for one rising edge, return at the following falling edge.
  task automatic cycle(input logic fr, input logic pw, input logic br, input logic prst,
                       input logic irst, input logic ack, input logic [15:0] d);
    drive(fr, pw, br, prst, irst, ack, d);
    @(posedge clk);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_addr = 0; m_mode = 0;
    m_wait = 0; m_req = 0; m_valid = 0; m_fault = 0;
  endtask

  // mode: 0 = waiting for request, 1 = fetching, 2 = timed out
  task automatic model_step(input logic fr, input logic pw, input logic br, input logic prst,
                            input logic irst, input logic ack, input logic [15:0] d);
    int operand_now;
    operand_now = m_ir % 2048;
    if (prst) m_pc = 0;
    else if (m_mode == 0 && pw) m_pc = br ? operand_now : (m_pc + 1) % 2048;
    if (prst) begin
      m_mode = 0; m_req = 0; m_wait = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      if (fr) begin
        m_mode = 1; m_req = 1; m_addr = m_pc; m_valid = 0; m_wait = 0;
      end
    end else if (m_mode == 1) begin
      if (fr || pw) m_fault = 1;
      if (ack) begin
        m_ir = int'(d); m_valid = 1; m_mode = 0; m_req = 0;
      end else begin
        m_wait++;
        if (m_wait == 8) begin
          m_mode = 2; m_req = 0; m_fault = 1;
        end
      end
    end
    if (irst) begin
      m_ir = 0; m_valid = 0;
    end
  endtask

  function automatic outs_t model_outs();
    return mk_out(11'(m_pc), 1'(m_req), 11'(m_addr), 1'(m_valid), m_mode != 0,
                  1'(m_fault), 5'(m_ir / 2048), 11'(m_ir % 2048));
  endfunction

  vec_t tbl[14];
  outs_t zero_o;

  initial begin
    logic fr, pw, br, prst, irst, ack;
    logic [15:0] d;

    zero_o = mk_out(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = mk_vec(1,0,0,0,0,0,16'h0000, mk_out(11'h000,1,11'h000,0,1,0,5'd0, 11'h000));
    tbl[1]  = mk_vec(0,0,0,0,0,0,16'h0000, mk_out(11'h000,1,11'h000,0,1,0,5'd0, 11'h000));
    tbl[2]  = mk_vec(0,0,0,0,0,0,16'h0000, mk_out(11'h000,1,11'h000,0,1,0,5'd0, 11'h000));
    tbl[3]  = mk_vec(0,0,0,0,0,1,16'h1803, mk_out(11'h000,0,11'h000,1,0,0,5'd3, 11'h003));
    tbl[4]  = mk_vec(0,1,1,0,0,0,16'h0000, mk_out(11'h003,0,11'h000,1,0,0,5'd3, 11'h003));
    tbl[5]  = mk_vec(1,1,0,0,0,0,16'h0000, mk_out(11'h004,1,11'h004,0,1,0,5'd3, 11'h003));
    tbl[6]  = mk_vec(0,0,0,0,0,1,16'h702A, mk_out(11'h004,0,11'h004,1,0,0,5'd14,11'h02A));
    tbl[7]  = mk_vec(0,1,1,0,0,0,16'h0000, mk_out(11'h02A,0,11'h004,1,0,0,5'd14,11'h02A));
    tbl[8]  = mk_vec(1,0,0,0,0,0,16'h0000, mk_out(11'h02A,1,11'h02A,0,1,0,5'd14,11'h02A));
    tbl[9]  = mk_vec(0,0,0,0,0,1,16'h0FFF, mk_out(11'h02A,0,11'h02A,1,0,0,5'd1, 11'h7FF));
    tbl[10] = mk_vec(0,1,1,0,0,0,16'h0000, mk_out(11'h7FF,0,11'h02A,1,0,0,5'd1, 11'h7FF));
    tbl[11] = mk_vec(0,1,0,0,0,0,16'h0000, mk_out(11'h000,0,11'h02A,1,0,0,5'd1, 11'h7FF));
    tbl[12] = mk_vec(0,0,0,0,1,0,16'h0000, mk_out(11'h000,0,11'h02A,0,0,0,5'd0, 11'h000));
    tbl[13] = mk_vec(0,0,0,0,0,1,16'hFFFF, mk_out(11'h000,0,11'h02A,0,0,0,5'd0, 11'h000));

    drive(0, 0, 0, 0, 0, 0, 16'h0);
    repeat (2) @(negedge clk);
    check_outs("reset_state", zero_o);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].fr, tbl[i].pw, tbl[i].br, tbl[i].prst, tbl[i].irst, tbl[i].ack, tbl[i].data);
      check_outs($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Ack timeout into FAULT, then recovery through pc_reset
    cycle(0, 1, 0, 0, 0, 0, 16'h0);
    chk("to_pc_inc", 32'(bus.pc_out), 32'h1);
    cycle(1, 0, 0, 0, 0, 0, 16'h0);
    chk("to_addr", 32'({bus.imem_req_out, bus.imem_addr_out}), 32'({1'b1, 11'h001}));
    repeat (7) cycle(0, 0, 0, 0, 0, 0, 16'h0);
    chk("to_7_waits", 32'({bus.fault_out, bus.imem_req_out, bus.busy_out}), 32'b011);
    cycle(0, 0, 0, 0, 0, 0, 16'h0);
    chk("to_8_waits", 32'({bus.fault_out, bus.imem_req_out, bus.busy_out}), 32'b101);
    cycle(1, 0, 0, 0, 0, 1, 16'h1234);
    chk("to_fault_sticky", 32'({bus.busy_out, bus.fault_out, bus.ir_valid_out, bus.imem_req_out}), 32'b1100);
    cycle(0, 0, 0, 1, 0, 0, 16'h0);
    chk("to_pc_reset", 32'({bus.fault_out, bus.busy_out, bus.imem_req_out, bus.pc_out}), 32'h0);

    // pc_wr during FETCH, then ir_reset coincident with ack
    cycle(0, 1, 0, 0, 0, 0, 16'h0);
    cycle(1, 0, 0, 0, 0, 0, 16'h0);
    chk("pw_fetch_addr", 32'(bus.imem_addr_out), 32'h1);
    cycle(0, 1, 0, 0, 0, 0, 16'h0);
    chk("pw_in_fetch", 32'({bus.pc_out, bus.fault_out, bus.busy_out, bus.imem_req_out}), 32'({11'h001, 3'b111}));
    cycle(0, 0, 0, 0, 1, 1, 16'hABCD);
    chk("irst_on_ack", 32'({bus.op_code_out, bus.operand_out, bus.ir_valid_out, bus.busy_out, bus.imem_req_out, bus.fault_out}),
        32'({5'd0, 11'h000, 4'b0001}));
    cycle(0, 0, 0, 1, 0, 0, 16'h0);
    chk("pw_fault_clear", 32'(bus.fault_out), 32'h0);

    // Asynchronous reset while fetching from PC=5
    repeat (5) cycle(0, 1, 0, 0, 0, 0, 16'h0);
    chk("ar_pc5", 32'(bus.pc_out), 32'h5);
    cycle(1, 0, 0, 0, 0, 0, 16'h0);
    chk("ar_fetching", 32'({bus.busy_out, bus.imem_req_out, bus.imem_addr_out}), 32'({2'b11, 11'h005}));
    #2 rst_n = 1'b0;
    #1 check_outs("async_reset", zero_o);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0, 0, 16'h0);
    check_outs("after_reset_release", zero_o);

    // Random stimulus against the reference model
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      fr   = ($urandom_range(0, 99) < 30);
      pw   = ($urandom_range(0, 99) < 20);
      br   = ($urandom_range(0, 99) < 50);
      prst = ($urandom_range(0, 99) < 4);
      irst = ($urandom_range(0, 99) < 5);
      ack  = ($urandom_range(0, 99) < 30);
      d    = 16'($urandom_range(0, 65535));
      model_step(fr, pw, br, prst, irst, ack, d);
      cycle(fr, pw, br, prst, irst, ack, d);
      check_outs($sformatf("random[%0d]", n), model_outs());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch responder on the other end of the decoder control interface. It owns the program counter and instruction register. It fetches instruction words from instruction memory over a req/ack handshake, and presents op_code/operand to the decoder. It acts on the decoder's ir_wr, pc_wr, branch, pc_reset and ir_reset strobes.

Parameters:
DATA_WIDTH, 11, operand width; also the PC/address width
INSTRUCTION_WIDTH, 15, MSB index of the instruction word (word is INSTRUCTION_WIDTH+1 bits; op_code = bits [INSTRUCTION_WIDTH:DATA_WIDTH])
MAX_WAIT, 8, FETCH cycles without ack before timeout fault

Ports:
clock_in  in  1  system clock, rising edge
reset_in  in  1  asynchronous, active-low reset
fetch_req_in  in  1  start fetch at PC (decoder ir_wr_out)
pc_wr_in  in  1  update PC (decoder pc_wr_out)
branch_in  in  1  with pc_wr_in: PC <= operand_out, else PC <= PC+1
pc_reset_in  in  1  synchronous PC clear / fetch abort
ir_reset_in  in  1  synchronous IR clear
imem_req_out  out  1  memory read request
imem_addr_out  out  DATA_WIDTH  read address
imem_ack_in  in  1  read data valid this cycle
imem_data_in  in  INSTRUCTION_WIDTH+1  instruction word
op_code_out  out  INSTRUCTION_WIDTH-DATA_WIDTH+1  IR op_code field, to decoder
operand_out  out  DATA_WIDTH  IR operand field
pc_out  out  DATA_WIDTH  current PC
ir_valid_out  out  1  IR holds a fetched word
busy_out  out  1  state != IDLE
fault_out  out  1  sticky protocol/timeout fault

Behaviour:
- Reset (reset_in=0, asynchronous): PC=0, IR=0, state=IDLE, wait counter=0. All outputs 0 (op_code_out=0 decodes as HLT).
- States: IDLE, FETCH, FAULT.
- IDLE to FETCH: fetch_req_in=1 at an edge. ir_valid_out clears at the same edge.
- imem_addr_out is registered at that edge from the post-update PC. If pc_wr_in is also high that cycle, the fetch uses the new PC.
- FETCH: imem_req_out=1 and imem_addr_out held stable.
  - Edge with imem_ack_in=1: IR <= imem_data_in, ir_valid_out=1, state to IDLE, imem_req_out drops next cycle.
  - Minimum fetch_req-to-ir_valid latency is 2 edges (ack in the first FETCH cycle).
- Wait counter increments on each FETCH edge without ack. If MAX_WAIT edges pass without ack: state to FAULT, fault_out=1, imem_req_out=0.
- imem_ack_in outside FETCH is ignored.
- PC update: accepted only in IDLE.
  - branch_in=1: PC <= operand_out.
  - branch_in=0: PC <= PC+1, modulo 2^DATA_WIDTH (all-ones wraps to 0).
- fetch_req_in or pc_wr_in while in FETCH: ignored and fault_out set. The fetch itself completes normally.
- FAULT: busy_out=1. Exit only via pc_reset_in or reset_in.
- pc_reset_in (highest synchronous priority): PC=0, state to IDLE, imem_req_out=0, wait counter=0, fault_out=0. IR is unaffected.
- ir_reset_in: IR=0, ir_valid_out=0. If coincident with an ack edge, ir_reset_in wins: IR=0, but the fetch still completes and state goes to IDLE.
- pc_reset_in and pc_wr_in in the same cycle: PC=0.

Decomposition:
- Shared package cpu_pkg:
  - opcode enum: HLT=0, STO, LD, LDI, ADD, ADDI, SUB, SUBI, BEQ, BNE, BGT, BGE, BLT, BLE, JMP=14
  - width constants DATA_WIDTH/INSTRUCTION_WIDTH
  - fetch_state_t {IDLE, FETCH, FAULT}
- One sub-module, program_counter: PC register with reset/increment/load and wrap rule. FSM, IR and timeout counter stay in fetch_unit.

Test Plan:
1. Reset low mid-FETCH with PC=5 -> all outputs 0 immediately (async); after release, IDLE with pc_out=0.
2. fetch_req_in at PC=0, ack after 2 wait cycles with data 16'h1803 -> imem_addr_out=0; op_code_out=5'b00011 (LDI), operand_out=11'h003, ir_valid_out=1 on the ack edge.
3. pc_wr_in, branch_in=0 at PC=11'h7FF -> pc_out=0. pc_wr_in, branch_in=1 with operand 11'h02A -> pc_out=11'h02A.
4. fetch_req_in together with pc_wr_in (branch_in=0) at PC=3 -> imem_addr_out=4.
5. No ack for 8 FETCH cycles -> fault_out=1, imem_req_out=0, busy_out=1. pc_reset_in -> fault_out=0, IDLE, pc_out=0.
6. pc_wr_in during FETCH -> PC unchanged, fault_out=1, fetch completes on ack. ir_reset_in on the ack edge -> op_code_out=0, ir_valid_out=0.
